// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
// Holds the controller register map, the sequencer state encoding, the
// latched configuration payload and the counter-word packing helper.
// Optional feature macro: PLL_CFG_FRAC_EN (adds the M fractional write).
package pll_cfg_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 32;

    // Reconfiguration controller register addresses
    localparam logic [ADDR_W-1:0] REG_MODE  = 6'd0;
    localparam logic [ADDR_W-1:0] REG_START = 6'd2;
    localparam logic [ADDR_W-1:0] REG_N     = 6'd3;
    localparam logic [ADDR_W-1:0] REG_M     = 6'd4;
    localparam logic [ADDR_W-1:0] REG_C     = 6'd5;
    localparam logic [ADDR_W-1:0] REG_MFRAC = 6'd7;
    localparam logic [ADDR_W-1:0] REG_BW    = 6'd8;
    localparam logic [ADDR_W-1:0] REG_CP    = 6'd9;

    // Output counter selected when writing the C register
    localparam logic [4:0] C0_IDX = 5'd0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_FRAC,
        ST_WR_C0,
        ST_WR_BW,
        ST_WR_CP,
        ST_WR_START,
        ST_WAIT_LOCK,
        ST_DONE
    } state_e;

    // Configuration captured at request time, already in register format
    typedef struct packed {
        logic [DATA_W-1:0] n_word;
        logic [DATA_W-1:0] m_word;
        logic [DATA_W-1:0] c0_word;
        logic [3:0]        bwctrl;
        logic [2:0]        cp_current;
`ifdef PLL_CFG_FRAC_EN
        logic [DATA_W-1:0] frac_k;
`endif
    } cfg_t;

    // Counter word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd
    function automatic logic [DATA_W-1:0] pack_cnt(input logic [7:0] hi,
                                                    input logic [7:0] lo,
                                                    input logic       odd);
        logic bypass;
        bypass = (hi == 8'd0) && (lo == 8'd0);
        return {14'd0, odd, bypass, hi, lo};
    endfunction

    function automatic logic is_wr_state(input state_e s);
        return (s == ST_WR_MODE) || (s == ST_WR_N)  || (s == ST_WR_M)  ||
               (s == ST_WR_FRAC) || (s == ST_WR_C0) || (s == ST_WR_BW) ||
               (s == ST_WR_CP)   || (s == ST_WR_START);
    endfunction

endpackage

// File: rtl/pll_cfg_avmm_wr.sv
// Single-write Avalon-MM master handshake.
// go_i loads addr_i/data_i and raises the write strobe; the command is held
// stable while mgmt_waitrequest_i is high. ack_c_o flags the accepting edge.
// A go_i in the same cycle as ack_c_o chains the next write without a gap.
// Ports: clk, rst, go_i, addr_i, data_i, ack_c_o, mgmt_address_o,
//        mgmt_write_o, mgmt_writedata_o, mgmt_waitrequest_i.
module pll_cfg_avmm_wr
    import pll_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              go_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_c_o,
    output logic [ADDR_W-1:0] mgmt_address_o,
    output logic              mgmt_write_o,
    output logic [DATA_W-1:0] mgmt_writedata_o,
    input  logic              mgmt_waitrequest_i
);

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    assign ack_c_o = wr_q && !mgmt_waitrequest_i;

    // Command register: load on go, drop strobe once accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (go_i) begin
            wr_q   <= 1'b1;
            addr_q <= addr_i;
            data_q <= data_i;
        end else if (ack_c_o) begin
            wr_q   <= 1'b0;
        end
    end

    assign mgmt_address_o   = addr_q;
    assign mgmt_write_o     = wr_q;
    assign mgmt_writedata_o = data_q;

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer.
// On cfg_req (while idle) latches a divider set, writes mode, N, M, [M frac],
// C0, bandwidth and charge pump to the reconfiguration controller, issues
// start, then waits for relock: done pulses on lock, err (sticky) on timeout.
// Parameters: LOCK_BLANK (cycles locked is ignored after start acceptance),
//             LOCK_TIMEOUT (cycles to err; must exceed LOCK_BLANK).
// Ports: clk, rst (async, active-high), cfg_req, counter/bw/cp config inputs,
//        frac_k (PLL_CFG_FRAC_EN only), mgmt_* Avalon-MM master, locked,
//        busy, done, err.
// Optional feature macro: PLL_CFG_FRAC_EN.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int unsigned LOCK_BLANK   = 16,
    parameter int unsigned LOCK_TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_req,
    input  logic [7:0]        m_hi,
    input  logic [7:0]        m_lo,
    input  logic [7:0]        n_hi,
    input  logic [7:0]        n_lo,
    input  logic [7:0]        c0_hi,
    input  logic [7:0]        c0_lo,
    input  logic              m_odd,
    input  logic              n_odd,
    input  logic              c0_odd,
    input  logic [3:0]        bwctrl,
    input  logic [2:0]        cp_current,
`ifdef PLL_CFG_FRAC_EN
    input  logic [DATA_W-1:0] frac_k,
`endif
    output logic [ADDR_W-1:0] mgmt_address,
    output logic              mgmt_write,
    output logic [DATA_W-1:0] mgmt_writedata,
    input  logic              mgmt_waitrequest,
    input  logic              locked,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              busy_q, done_q;
    logic              go_c, ack_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;

    // State, latched config, lock counter and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Next state plus launch of the write belonging to the state being entered
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        go_c      = 1'b0;
        wr_addr_c = REG_MODE;
        wr_data_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    cfg_d.n_word     = pack_cnt(n_hi, n_lo, n_odd);
                    cfg_d.m_word     = pack_cnt(m_hi, m_lo, m_odd);
                    cfg_d.c0_word    = pack_cnt(c0_hi, c0_lo, c0_odd) |
                                       {9'd0, C0_IDX, 18'd0};
                    cfg_d.bwctrl     = bwctrl;
                    cfg_d.cp_current = cp_current;
`ifdef PLL_CFG_FRAC_EN
                    cfg_d.frac_k     = frac_k;
`endif
                    err_d   = 1'b0;
                    state_d = ST_WR_MODE;
                end
            end
            ST_WR_MODE: if (ack_c) state_d = ST_WR_N;
            ST_WR_N:    if (ack_c) state_d = ST_WR_M;
            ST_WR_M: begin
                if (ack_c) begin
`ifdef PLL_CFG_FRAC_EN
                    state_d = ST_WR_FRAC;
`else
                    state_d = ST_WR_C0;
`endif
                end
            end
`ifdef PLL_CFG_FRAC_EN
            ST_WR_FRAC: if (ack_c) state_d = ST_WR_C0;
`endif
            ST_WR_C0:   if (ack_c) state_d = ST_WR_BW;
            ST_WR_BW:   if (ack_c) state_d = ST_WR_CP;
            ST_WR_CP:   if (ack_c) state_d = ST_WR_START;
            ST_WR_START: begin
                if (ack_c) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Saturating count; locked is only trusted after blanking
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if ((cnt_q >= CNT_W'(LOCK_BLANK)) && locked) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        go_c = is_wr_state(state_d) && (state_d != state_q);

        case (state_d)
            ST_WR_N: begin
                wr_addr_c = REG_N;
                wr_data_c = cfg_q.n_word;
            end
            ST_WR_M: begin
                wr_addr_c = REG_M;
                wr_data_c = cfg_q.m_word;
            end
`ifdef PLL_CFG_FRAC_EN
            ST_WR_FRAC: begin
                wr_addr_c = REG_MFRAC;
                wr_data_c = cfg_q.frac_k;
            end
`endif
            ST_WR_C0: begin
                wr_addr_c = REG_C;
                wr_data_c = cfg_q.c0_word;
            end
            ST_WR_BW: begin
                wr_addr_c = REG_BW;
                wr_data_c = {28'd0, cfg_q.bwctrl};
            end
            ST_WR_CP: begin
                wr_addr_c = REG_CP;
                wr_data_c = {29'd0, cfg_q.cp_current};
            end
            ST_WR_START: begin
                wr_addr_c = REG_START;
                wr_data_c = DATA_W'(1);
            end
            default: begin
                wr_addr_c = REG_MODE;
                wr_data_c = '0;
            end
        endcase
    end

    pll_cfg_avmm_wr u_avmm_wr (
        .clk                (clk),
        .rst                (rst),
        .go_i               (go_c),
        .addr_i             (wr_addr_c),
        .data_i             (wr_data_c),
        .ack_c_o            (ack_c),
        .mgmt_address_o     (mgmt_address),
        .mgmt_write_o       (mgmt_write),
        .mgmt_writedata_o   (mgmt_writedata),
        .mgmt_waitrequest_i (mgmt_waitrequest)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Self-checking bench for pll_cfg_seq: expected controller writes and
// done/err events are queued when a request is driven and checked by a
// monitor as the DUT produces them.
module tb_pll_cfg_seq;

    localparam int unsigned BLANK = 16;
    localparam int unsigned TMO   = 300;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0;
    logic [7:0]  m_hi = '0, m_lo = '0, n_hi = '0, n_lo = '0, c0_hi = '0, c0_lo = '0;
    logic        m_odd = 1'b0, n_odd = 1'b0, c0_odd = 1'b0;
    logic [3:0]  bwctrl = '0;
    logic [2:0]  cp_current = '0;
`ifdef PLL_CFG_FRAC_EN
    logic [31:0] frac_k = '0;
`endif
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;
    logic        locked = 1'b0;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wr_t exp_q[$];
    int  done_max_q[$];
    int  err_lat_q[$];

    // Monitor-owned state
    int          start_cyc = 0;
    int          start_cnt = 0;
    int          done_cnt  = 0;
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic        done_prev = 1'b0;
    logic        err_prev  = 1'b0;

    logic        stall_on_m = 1'b0;
    int          req_cyc = 0;

    pll_cfg_seq #(
        .LOCK_BLANK   (BLANK),
        .LOCK_TIMEOUT (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_req          (cfg_req),
        .m_hi             (m_hi),
        .m_lo             (m_lo),
        .n_hi             (n_hi),
        .n_lo             (n_lo),
        .c0_hi            (c0_hi),
        .c0_lo            (c0_lo),
        .m_odd            (m_odd),
        .n_odd            (n_odd),
        .c0_odd           (c0_odd),
        .bwctrl           (bwctrl),
        .cp_current       (cp_current),
`ifdef PLL_CFG_FRAC_EN
        .frac_k           (frac_k),
`endif
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .locked           (locked),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Stall the M write for five cycles when armed
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_on_m && mgmt_write && mgmt_address == 6'd4 && !mgmt_waitrequest) begin
                mgmt_waitrequest = 1'b1;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                mgmt_waitrequest = 1'b0;
            end
        end
    end

    // Monitor: sampled mid-cycle, events land on the following rising edge
    always @(negedge clk) begin
        if (mgmt_write) chk("write_only_while_busy", 32'(busy), 32'd1);
        if (prev_stall) begin
            chk("hold_write", 32'(mgmt_write), 32'd1);
            chk("hold_addr", 32'(mgmt_address), 32'(prev_addr));
            chk("hold_data", mgmt_writedata, prev_data);
        end
        if (mgmt_write && mgmt_waitrequest) stall_cnt++;
        prev_stall = mgmt_write && mgmt_waitrequest;
        prev_addr  = mgmt_address;
        prev_data  = mgmt_writedata;

        if (mgmt_write && !mgmt_waitrequest) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(mgmt_address), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mgmt_address), 32'(e.a));
                chk("wr_data", mgmt_writedata, e.d);
            end
            if (mgmt_address == 6'd2) begin
                start_cyc = cyc + 1;
                start_cnt++;
            end
        end

        if (done) begin
            int lat;
            lat = cyc - start_cyc;
            chk("done_single_cycle", 32'(done_prev), 32'd0);
            chk("done_busy_low", 32'(busy), 32'd0);
            chk("done_not_before_blank", 32'(lat >= int'(BLANK) + 1), 32'd1);
            if (done_max_q.size() == 0) chk("unexpected_done_latency", 32'(lat), 32'hFFFF_FFFF);
            else chk("done_not_late", 32'(lat <= done_max_q.pop_front()), 32'd1);
            done_cnt++;
        end

        if (err && !err_prev) begin
            int lat;
            lat = cyc - start_cyc;
            chk("err_busy_low", 32'(busy), 32'd0);
            if (err_lat_q.size() == 0) chk("unexpected_err_latency", 32'(lat), 32'hFFFF_FFFF);
            else chk("err_latency", 32'(lat), 32'(err_lat_q.pop_front()));
        end
        done_prev = done;
        err_prev  = err;
    end

    // Drive one request and queue the writes it must produce
    task automatic send_req(input logic [7:0] mh, input logic [7:0] ml, input logic mo,
                            input logic [7:0] nh, input logic [7:0] nl, input logic no,
                            input logic [7:0] ch, input logic [7:0] cl, input logic co,
                            input logic [3:0] bw, input logic [2:0] cp,
                            input logic [31:0] m_exp, input logic [31:0] n_exp,
                            input logic [31:0] c_exp);
        @(posedge clk);
        #1;
        m_hi = mh; m_lo = ml; m_odd = mo;
        n_hi = nh; n_lo = nl; n_odd = no;
        c0_hi = ch; c0_lo = cl; c0_odd = co;
        bwctrl = bw; cp_current = cp;
        cfg_req = 1'b1;
        exp_q.push_back('{6'd0, 32'd0});
        exp_q.push_back('{6'd3, n_exp});
        exp_q.push_back('{6'd4, m_exp});
`ifdef PLL_CFG_FRAC_EN
        frac_k = 32'h00AB_CDEF;
        exp_q.push_back('{6'd7, 32'h00AB_CDEF});
`endif
        exp_q.push_back('{6'd5, c_exp});
        exp_q.push_back('{6'd8, {28'd0, bw}});
        exp_q.push_back('{6'd9, {29'd0, cp}});
        exp_q.push_back('{6'd2, 32'd1});
        @(posedge clk);
        #1;
        req_cyc = cyc;
        cfg_req = 1'b0;
        // Scramble inputs: the sequence must use the latched copy
        m_hi = 8'($urandom); m_lo = 8'($urandom); n_hi = 8'($urandom);
        n_lo = 8'($urandom); c0_hi = 8'($urandom); c0_lo = 8'($urandom);
        bwctrl = 4'($urandom); cp_current = 3'($urandom);
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_write", 32'(mgmt_write), 32'd1);
        chk("req_err_clear", 32'(err), 32'd0);
        chk("req_first_addr", 32'(mgmt_address), 32'd0);
    endtask

    task automatic wait_start(input int bound, input int s0);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (start_cnt > s0 && cyc >= start_cyc) break;
        end
        chk("start_accepted", 32'(start_cnt - s0), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        chk("busy_released", 32'(busy), 32'd0);
    endtask

    initial begin
        int s0, d0, st0;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s0, d0, st0;

        // Reset and quiet idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 32'(mgmt_address), 32'd0);
        chk("rst_write", 32'(mgmt_write), 32'd0);
        chk("rst_data", mgmt_writedata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk("idle_write", 32'(mgmt_write), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Nominal retune, lock 20 cycles after start
        s0 = start_cnt; d0 = done_cnt;
        done_max_q.push_back(22);
        send_req(8'd48, 8'd48, 1'b0, 8'd3, 8'd2, 1'b1, 8'd10, 8'd10, 1'b0, 4'h7, 3'h3,
                 32'h0000_3030, 32'h0002_0302, 32'h0000_0A0A);
        wait_start(40, s0);
`ifdef PLL_CFG_FRAC_EN
        chk("start_latency", 32'(start_cyc - req_cyc), 32'd8);
`else
        chk("start_latency", 32'(start_cyc - req_cyc), 32'd7);
`endif
        repeat (20) @(posedge clk);
        #1;
        locked = 1'b1;
        wait_idle(60);
        locked = 1'b0;
        repeat (3) @(posedge clk);
        chk("done_count_nominal", 32'(done_cnt - d0), 32'd1);

        // Stalled M write, plus an ignored request while busy
        s0 = start_cnt; d0 = done_cnt; st0 = stall_cnt;
        stall_on_m = 1'b1;
        done_max_q.push_back(BLANK + 3);
        send_req(8'h14, 8'h13, 1'b1, 8'd1, 8'd1, 1'b0, 8'd5, 8'd4, 1'b1, 4'h2, 3'h5,
                 32'h0002_1413, 32'h0000_0101, 32'h0002_0504);
        @(posedge clk);
        #1;
        cfg_req = 1'b1;
        m_hi = 8'hEE; n_hi = 8'hEE; c0_hi = 8'hEE;
        @(posedge clk);
        #1;
        cfg_req = 1'b0;
        wait_start(60, s0);
        stall_on_m = 1'b0;
        chk("stall_cycles", 32'(stall_cnt - st0), 32'd5);
`ifdef PLL_CFG_FRAC_EN
        chk("start_latency_stalled", 32'(start_cyc - req_cyc), 32'd13);
`else
        chk("start_latency_stalled", 32'(start_cyc - req_cyc), 32'd12);
`endif
        repeat (5) @(posedge clk);
        #1;
        locked = 1'b1;
        wait_idle(60);
        locked = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            chk("no_queued_request", 32'(mgmt_write | busy), 32'd0);
        end
        chk("done_count_stalled", 32'(done_cnt - d0), 32'd1);

        // Locked stuck high through start: blanking governs done
        s0 = start_cnt; d0 = done_cnt;
        locked = 1'b1;
        done_max_q.push_back(BLANK + 3);
        send_req(8'd1, 8'd0, 1'b0, 8'd0, 8'd1, 1'b1, 8'd0, 8'd0, 1'b0, 4'hF, 3'h7,
                 32'h0000_0100, 32'h0002_0001, 32'h0001_0000);
        wait_start(40, s0);
        wait_idle(60);
        locked = 1'b0;
        repeat (3) @(posedge clk);
        chk("done_count_stuck_lock", 32'(done_cnt - d0), 32'd1);

        // Lock timeout, then a fresh request clears err
        s0 = start_cnt; d0 = done_cnt;
        err_lat_q.push_back(TMO);
        send_req(8'd48, 8'd48, 1'b0, 8'd3, 8'd2, 1'b1, 8'd10, 8'd10, 1'b0, 4'h7, 3'h3,
                 32'h0000_3030, 32'h0002_0302, 32'h0000_0A0A);
        wait_start(40, s0);
        wait_idle(TMO + 20);
        chk("timeout_err", 32'(err), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);
        chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        s0 = start_cnt;
        done_max_q.push_back(BLANK + 3);
        send_req(8'd48, 8'd48, 1'b0, 8'd3, 8'd2, 1'b1, 8'd10, 8'd10, 1'b0, 4'h7, 3'h3,
                 32'h0000_3030, 32'h0002_0302, 32'h0000_0A0A);
        wait_start(40, s0);
        locked = 1'b1;
        wait_idle(60);
        locked = 1'b0;
        chk("err_after_retry", 32'(err), 32'd0);

        // Reset during WR_C0 with a request issued while busy
        send_req(8'h14, 8'h13, 1'b1, 8'd1, 8'd1, 1'b0, 8'd5, 8'd4, 1'b1, 4'h2, 3'h5,
                 32'h0002_1413, 32'h0000_0101, 32'h0002_0504);
        cfg_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cfg_req = 1'b0;
            if (mgmt_write && mgmt_address == 6'd5) break;
        end
        chk("reached_wr_c0", 32'(mgmt_address), 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_rst_write", 32'(mgmt_write), 32'd0);
        chk("mid_rst_addr", 32'(mgmt_address), 32'd0);
        chk("mid_rst_data", mgmt_writedata, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle", 32'(mgmt_write | busy), 32'd0);
        end

        chk("sb_writes_left", 32'(exp_q.size()), 32'd0);
        chk("sb_done_left", 32'(done_max_q.size()), 32'd0);
        chk("sb_err_left", 32'(err_lat_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
